// File: rtl/split_vector_loader.sv
// split_vector_loader: packs valid/ready operand words LSB-first into one wide stimulus vector,
// presents it to a split_* module, samples its result after EVAL_LAT cycles and keeps
// saturating pass/fail counters plus a sticky framing error flag.
// Optional: define SPLIT_LOADER_PARITY_EN to check even parity (in_par) on every accepted word.
module split_vector_loader #(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned VEC_W    = 516,
  parameter int unsigned EVAL_LAT = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              in_par,
  output logic              in_ready,
  output logic [VEC_W-1:0]  vec_o,
  output logic              vec_valid,
  input  logic              vec_ready,
  input  logic              x_i,
  output logic              res_valid,
  output logic              res_x,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              err
);

  localparam int unsigned WORDS = (VEC_W + WORD_W - 1) / WORD_W;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [3:0] LAT = 4'(EVAL_LAT);

  typedef enum logic [1:0] {StFill, StPresent, StWait} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       dly_q, dly_d;
  logic [VEC_W-1:0] vec_q;
  logic             res_valid_q, res_valid_d;
  logic             res_x_q, res_x_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [WORDS-1:0] word_we;
  logic             accept, frame_bad, par_bad, vec_clr;

  // Held low while rst is asserted so no word can slip in during reset.
  assign in_ready  = (state_q == StFill) && !rst;
  assign accept    = in_valid && in_ready;
  assign frame_bad = in_last && (idx_q != LAST_IDX);

`ifdef SPLIT_LOADER_PARITY_EN
  assign par_bad = (in_par != ^in_data);
`else
  logic unused_in_par;
  assign unused_in_par = in_par;
  assign par_bad       = 1'b0;
`endif

  // A bad word throws away whatever has been packed so far.
  assign vec_clr = accept && (frame_bad || par_bad);

  // Next-state, word write enables, result capture and counter updates.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dly_d       = dly_q;
    res_valid_d = 1'b0;
    res_x_d     = res_x_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    err_d       = err_q;
    word_we     = '0;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          if (frame_bad || par_bad) begin
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            word_we[idx_q] = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = StPresent;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end
      StPresent: begin
        if (vec_ready) begin
          dly_d   = LAT;
          state_d = StWait;
        end
      end
      StWait: begin
        // dly_q == 1 means this edge is the one where the counter reaches zero.
        if (dly_q <= 4'd1) begin
          dly_d       = '0;
          res_valid_d = 1'b1;
          res_x_d     = x_i;
          state_d     = StFill;
          if (x_i) begin
            if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
          end else begin
            if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
          end
        end else begin
          dly_d = dly_q - 4'd1;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Control and result state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFill;
      idx_q       <= '0;
      dly_q       <= '0;
      res_valid_q <= 1'b0;
      res_x_q     <= 1'b0;
      pass_q      <= '0;
      fail_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dly_q       <= dly_d;
      res_valid_q <= res_valid_d;
      res_x_q     <= res_x_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      err_q       <= err_d;
    end
  end

  // One register slice per word; the final slice is clipped to VEC_W.
  for (genvar w = 0; w < WORDS; w++) begin : g_word
    localparam int unsigned Lo = w * WORD_W;
    localparam int unsigned Hi = (Lo + WORD_W > VEC_W) ? VEC_W - 1 : Lo + WORD_W - 1;

    // Load slice w when word w is accepted; clear on reset or a discarded vector.
    always_ff @(posedge clk) begin
      if (rst || vec_clr) begin
        vec_q[Hi:Lo] <= '0;
      end else if (word_we[w]) begin
        vec_q[Hi:Lo] <= in_data[Hi-Lo:0];
      end
    end
  end

  assign vec_o     = vec_q;
  assign vec_valid = (state_q == StPresent);
  assign res_valid = res_valid_q;
  assign res_x     = res_x_q;
  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign err       = err_q;

endmodule

// File: doc/split_vector_loader.md
Name: split_vector_loader

Overview:
- Upstream feeder for the split_* BDD benchmark modules. Accepts operand words over a valid/ready stream and packs them LSB-first into one wide stimulus vector (var_0 at bit 0, then var_1, and so on).
- Presents the packed vector to the split module under test, waits a fixed evaluation latency, then samples its 1-bit result `x`.
- Keeps saturating pass/fail counters and a sticky framing-error flag for the bench/controller.

Parameters:
- WORD_W, 32: input word width in bits.
- VEC_W, 516: packed vector width. 516 is the sum of all var_* widths of a split module.
- EVAL_LAT, 2: cycles from vector handshake to sampling `x_i`. Legal range 1..15.
- CNT_W, 16: width of the pass/fail counters.
- Derived, not overridable: WORDS = ceil(VEC_W/WORD_W). This is 17 at the defaults.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous active-high reset.
- in_data, input, WORD_W: operand word.
- in_valid, input, 1: word valid.
- in_last, input, 1: final word of a vector.
- in_par, input, 1: even-parity bit over in_data. Used only with the optional feature.
- in_ready, output, 1: loader accepts a word this cycle.
- vec_o, output, VEC_W: packed stimulus vector, wired to the split module's var_* inputs.
- vec_valid, output, 1: vec_o is stable and offered.
- vec_ready, input, 1: downstream takes the vector.
- x_i, input, 1: result from the split module.
- res_valid, output, 1: one-cycle pulse when a result is captured.
- res_x, output, 1: captured result.
- pass_cnt, output, CNT_W: number of results with x=1, saturating.
- fail_cnt, output, CNT_W: number of results with x=0, saturating.
- err, output, 1: sticky framing/parity error.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=FILL, word index=0, vec_o=0, vec_valid=0, in_ready=0 during rst and 1 the cycle after, res_valid=0, res_x=0, pass_cnt=0, fail_cnt=0, err=0.
- Reset mid-operation: a partial vector or pending result is discarded. Nothing is counted.
- FILL state:
  - in_ready=1.
  - A word transfers when in_valid&&in_ready.
  - Word k is written to vec_o[k*WORD_W +: WORD_W], clipped to VEC_W. The upper WORD_W*WORDS-VEC_W bits of the last word are dropped.
  - After word WORDS-1 is accepted: go to PRESENT, index resets to 0, in_ready=0 from the next cycle.
- Early last: in_last=1 on word k<WORDS-1 causes the following.
  - Set err.
  - Zero vec_o.
  - Index resets to 0.
  - Stay in FILL; no vector is presented.
  - in_last on word WORDS-1 is normal. in_last=0 on word WORDS-1 is also accepted, with no error.
- PRESENT state:
  - vec_valid=1 and vec_o is held stable.
  - On vec_valid&&vec_ready: vec_valid=0 next cycle, load the delay counter with EVAL_LAT, go to WAIT.
- WAIT state: decrement the delay counter each cycle. On the cycle the counter reaches 0:
  - sample x_i into res_x;
  - res_valid=1 for exactly one cycle;
  - increment pass_cnt if x_i=1, else fail_cnt;
  - go to FILL.
- Total latency: x_i is sampled EVAL_LAT cycles after the vec handshake edge.
- Counters saturate at 2^CNT_W-1 and hold there. res_valid still pulses when a counter is saturated.
- in_valid is ignored outside FILL; no words are accepted in PRESENT or WAIT.
- err is cleared only by rst.

Optional Feature:
- Macro: SPLIT_LOADER_PARITY_EN.
- Defined: each accepted word is checked against in_par, where in_par must equal ^in_data. On mismatch:
  - set err;
  - discard the partial vector (vec_o zeroed);
  - index resets to 0;
  - stay in FILL.
- Undefined: in_par is ignored and has no logic. The port remains present.

Test Plan:
- Nominal: send 17 words 0x00000001..0x00000011 with in_last on the 17th, vec_ready=1, x_i=1. Expect:
  - vec_valid high one cycle after word 17;
  - vec_o[31:0]=1 and vec_o[515:512]=0x1;
  - res_valid pulse 2 cycles after the handshake;
  - pass_cnt=1, fail_cnt=0.
- Backpressure: hold vec_ready=0 for 10 cycles after PRESENT. Expect:
  - vec_valid stays 1 and vec_o stays constant;
  - in_ready=0 throughout;
  - result only EVAL_LAT cycles after vec_ready rises.
- Early last: in_last on word 5. Expect err=1, no vec_valid, next 17-word vector accepted normally with its vec_o free of stale data.
- Saturation: with CNT_W=4, run 17 vectors with x_i=0. Expect fail_cnt=15 and held, res_valid pulsed 17 times.
- Reset mid-fill: assert rst after word 9 of 17. Expect all outputs at reset values and no res_valid. The next full vector is accepted from index 0.
- Parity (SPLIT_LOADER_PARITY_EN defined): in_data=0x3 with in_par=1. Expect err=1 and the vector discarded. With the macro undefined, the same stimulus produces no error.
